// File: rtl/ark_pkg.sv
// Shared types, default sizes and elaboration helpers for the AddRoundKey engine.
package ark_pkg;

  localparam int AES_BLOCK_W  = 128;
  localparam int AES_MAX_KEYS = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ark_state_t;

  function automatic int beats(input int block_w, input int lane_w);
    return (lane_w > 0) ? (block_w / lane_w) : 0;
  endfunction

  // Lanes must be whole bytes, a supported width, and tile the block exactly.
  function automatic bit lane_w_legal(input int block_w, input int lane_w);
    bit width_ok;
    width_ok = (lane_w == 8) || (lane_w == 16) || (lane_w == 32) ||
               (lane_w == 64) || (lane_w == 128);
    return width_ok && (lane_w <= block_w) && ((block_w % lane_w) == 0);
  endfunction

endpackage

// File: rtl/ark_if.sv
// Input and output valid/ready channels of the AddRoundKey engine.
interface ark_if
  import ark_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int IDX_W   = $clog2(AES_MAX_KEYS)
);
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_state;
  logic [IDX_W-1:0]   in_key_idx;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_state;
  logic [IDX_W-1:0]   out_key_idx;
  logic               out_err;

  modport master (
    output in_valid, in_state, in_key_idx, out_ready,
    input  in_ready, out_valid, out_state, out_key_idx, out_err
  );

  modport slave (
    input  in_valid, in_state, in_key_idx, out_ready,
    output in_ready, out_valid, out_state, out_key_idx, out_err
  );
endinterface

// File: rtl/ark_key_store.sv
// Round-key register file: one synchronous write port, one combinational read port.
module ark_key_store
  import ark_pkg::*;
#(
  parameter int BLOCK_W  = AES_BLOCK_W,
  parameter int NUM_KEYS = AES_MAX_KEYS,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [BLOCK_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [BLOCK_W-1:0] rdata_o
);
  localparam logic [IDX_W:0] NUM_KEYS_L = (IDX_W + 1)'(NUM_KEYS);

  logic [BLOCK_W-1:0] mem_q [NUM_KEYS];
  logic               waddr_ok;
  logic               raddr_ok;

  assign waddr_ok = ({1'b0, waddr_i} < NUM_KEYS_L);
  assign raddr_ok = ({1'b0, raddr_i} < NUM_KEYS_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && waddr_ok) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Unpopulated slots read as the all-zero key so the state passes through.
  assign rdata_o = raddr_ok ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/ark_engine.sv
// Sequential AddRoundKey: XORs a latched state with a latched round key LANE_W bits per cycle.
module ark_engine
  import ark_pkg::*;
#(
  parameter int BLOCK_W  = AES_BLOCK_W,
  parameter int LANE_W   = 32,
  parameter int NUM_KEYS = AES_MAX_KEYS,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_we,
  input  logic [IDX_W-1:0]   key_waddr,
  input  logic [BLOCK_W-1:0] key_wdata,
  ark_if.slave               bus
);
  localparam int BEATS  = beats(BLOCK_W, LANE_W);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W:0]    NUM_KEYS_L = (IDX_W + 1)'(NUM_KEYS);

  if (!lane_w_legal(BLOCK_W, LANE_W)) begin : g_bad_lane
    $error("ark_engine: LANE_W must be 8/16/32/64/128 and divide BLOCK_W");
  end

  ark_state_t         state_q;
  logic [BEAT_W-1:0]  beat_cnt_q;
  logic [BLOCK_W-1:0] key_q;
  logic [BLOCK_W-1:0] out_state_q;
  logic [BLOCK_W-1:0] out_state_d;
  logic [IDX_W-1:0]   out_key_idx_q;
  logic               out_valid_q;
  logic               out_err_q;
  logic [BLOCK_W-1:0] key_rd;
  logic               idx_oob;

  ark_key_store #(
    .BLOCK_W  (BLOCK_W),
    .NUM_KEYS (NUM_KEYS),
    .IDX_W    (IDX_W)
  ) u_key_store (
    .clk     (clk),
    .rst     (rst),
    .we_i    (key_we),
    .waddr_i (key_waddr),
    .wdata_i (key_wdata),
    .raddr_i (bus.in_key_idx),
    .rdata_o (key_rd)
  );

  assign idx_oob = ({1'b0, bus.in_key_idx} >= NUM_KEYS_L);

  // Only the lane selected by beat_cnt is keyed; the rest keep their current value.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    localparam logic [BEAT_W-1:0] LANE_ID = BEAT_W'(gi);
    assign out_state_d[gi*LANE_W +: LANE_W] = (beat_cnt_q == LANE_ID)
        ? (out_state_q[gi*LANE_W +: LANE_W] ^ key_q[gi*LANE_W +: LANE_W])
        :  out_state_q[gi*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      key_q         <= '0;
      out_state_q   <= '0;
      out_key_idx_q <= '0;
      out_valid_q   <= 1'b0;
      out_err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            out_state_q   <= bus.in_state;
            key_q         <= key_rd;
            out_key_idx_q <= bus.in_key_idx;
            out_err_q     <= idx_oob;
            beat_cnt_q    <= '0;
            state_q       <= BUSY;
          end
        end
        BUSY: begin
          out_state_q <= out_state_d;
          if (beat_cnt_q == LAST_BEAT) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready follows the state register only, never the downstream out_ready.
  assign bus.in_ready    = (state_q == IDLE) && !rst;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_state   = out_state_q;
  assign bus.out_key_idx = out_key_idx_q;
  assign bus.out_err     = out_err_q;

endmodule

// File: tb/tb_ark_engine.sv
// Drives four engine configurations in lockstep and checks them against an array-based key model.
module tb_ark_engine;

  localparam int NCFG = 4;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_IN  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  function automatic int cfg_lane(input int i);
    case (i)
      0:       return 32;
      1:       return 8;
      2:       return 64;
      default: return 128;
    endcase
  endfunction

  function automatic int cfg_nk(input int i);
    return (i == 0) ? 15 : 11;
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_we = 1'b0;
  logic [3:0]   key_waddr = '0;
  logic [127:0] key_wdata = '0;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic [3:0]   in_key_idx = '0;
  logic         out_ready = 1'b1;

  logic [NCFG-1:0] ir, ov, oe;
  logic [127:0]    os [NCFG];
  logic [3:0]      ok [NCFG];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    ark_if #(.BLOCK_W(128), .IDX_W(4)) bus ();
    assign bus.in_valid   = in_valid;
    assign bus.in_state   = in_state;
    assign bus.in_key_idx = in_key_idx;
    assign bus.out_ready  = out_ready;
    assign ir[gi] = bus.in_ready;
    assign ov[gi] = bus.out_valid;
    assign oe[gi] = bus.out_err;
    assign os[gi] = bus.out_state;
    assign ok[gi] = bus.out_key_idx;

    ark_engine #(
      .BLOCK_W  (128),
      .LANE_W   (cfg_lane(gi)),
      .NUM_KEYS (cfg_nk(gi)),
      .IDX_W    (4)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_we    (key_we),
      .key_waddr (key_waddr),
      .key_wdata (key_wdata),
      .bus       (bus)
    );
  end

  int checks = 0;
  int failures = 0;
  int blk_n = 0;

  logic [127:0] mk [16];
  logic [127:0] got_s [NCFG];
  int           first_c [NCFG];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic write_key(input logic [3:0] a, input logic [127:0] d);
    @(negedge clk);
    key_we = 1'b1; key_waddr = a; key_wdata = d;
    @(posedge clk); #1;
    key_we = 1'b0;
    mk[a] = d;
  endtask

  // One block through all configurations; optional same-cycle key write and output backpressure.
  task automatic run_block(input logic [3:0] idx, input logic [127:0] st, input bit wr,
                           input logic [3:0] wa, input logic [127:0] wd, input bit hold);
    logic [127:0] exp_s [NCFG];
    logic         exp_e [NCFG];
    bit           all_seen;
    for (int i = 0; i < NCFG; i++) begin
      exp_e[i] = (int'(idx) >= cfg_nk(i));
      exp_s[i] = exp_e[i] ? st : (st ^ mk[idx]);
      first_c[i] = -1;
      got_s[i] = '0;
    end
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) chk($sformatf("rdy%0d", i), ir[i], 1'b1);
    in_valid = 1'b1; in_state = st; in_key_idx = idx; out_ready = !hold;
    if (wr) begin key_we = 1'b1; key_waddr = wa; key_wdata = wd; end
    @(posedge clk); #1;
    in_valid = 1'b0; key_we = 1'b0;
    if (wr) mk[wa] = wd;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      all_seen = 1'b1;
      for (int i = 0; i < NCFG; i++) begin
        if (first_c[i] < 0 && ov[i]) begin
          first_c[i] = c;
          got_s[i] = os[i];
          chk($sformatf("err%0d", i), oe[i], exp_e[i]);
          chk($sformatf("kidx%0d", i), ok[i], idx);
        end
        if (first_c[i] < 0) all_seen = 1'b0;
      end
      if (all_seen) break;
    end
    for (int i = 0; i < NCFG; i++) begin
      chk($sformatf("lat%0d", i), first_c[i], 128 / cfg_lane(i) + 1);
      chk($sformatf("state%0d", i), got_s[i], exp_s[i]);
    end
    if (hold) begin
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
          chk($sformatf("bp_valid%0d", i), ov[i], 1'b1);
          chk($sformatf("bp_state%0d", i), os[i], exp_s[i]);
          chk($sformatf("bp_rdy%0d", i), ir[i], 1'b0);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) begin
        chk($sformatf("rel_rdy%0d", i), ir[i], 1'b1);
        chk($sformatf("rel_valid%0d", i), ov[i], 1'b0);
      end
    end
    out_ready = 1'b1;
    $display("blk %0d idx=%0d in=%h out0=%h lat=%0d/%0d/%0d/%0d", blk_n, idx, st, got_s[0],
             first_c[0], first_c[1], first_c[2], first_c[3]);
    blk_n++;
  endtask

  initial begin
    logic [127:0] st;
    bit           seen;
    for (int i = 0; i < 16; i++) mk[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      chk($sformatf("rst_rdy%0d", i), ir[i], 1'b0);
      chk($sformatf("rst_valid%0d", i), ov[i], 1'b0);
      chk($sformatf("rst_state%0d", i), os[i], '0);
      chk($sformatf("rst_kidx%0d", i), ok[i], '0);
      chk($sformatf("rst_err%0d", i), oe[i], 1'b0);
    end
    rst = 1'b0; #1;
    for (int i = 0; i < NCFG; i++) chk($sformatf("post_rst_rdy%0d", i), ir[i], 1'b1);

    // FIPS-197 round 0 vector on every lane width
    write_key(4'd0, FIPS_KEY);
    run_block(4'd0, FIPS_IN, 1'b0, 4'd0, '0, 1'b0);
    for (int i = 0; i < NCFG; i++) chk($sformatf("fips%0d", i), got_s[i], FIPS_OUT);

    // Backpressure
    run_block(4'd0, rnd128(), 1'b0, 4'd0, '0, 1'b1);

    // Index 14: in range for 15 slots, out of range for 11
    write_key(4'd14, rnd128());
    st = rnd128();
    run_block(4'd14, st, 1'b0, 4'd0, '0, 1'b0);
    chk("oob_state", got_s[1], st);

    // Same-cycle write and accept uses the old key
    write_key(4'd3, '0);
    st = rnd128();
    run_block(4'd3, st, 1'b1, 4'd3, {128{1'b1}}, 1'b0);
    chk("samecyc_old", got_s[0], st);
    st = rnd128();
    run_block(4'd3, st, 1'b0, 4'd0, '0, 1'b0);
    chk("samecyc_new", got_s[0], ~st);

    // Randomized blocks
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) != 0) write_key(4'($urandom_range(0, 15)), rnd128());
      run_block(4'($urandom_range(0, 15)), rnd128(), ($urandom_range(0, 5) == 0),
                4'($urandom_range(0, 15)), rnd128(), ($urandom_range(0, 7) == 0));
    end

    // Reset during BUSY drops the block and clears the key store
    @(negedge clk);
    in_valid = 1'b1; in_state = rnd128(); in_key_idx = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NCFG; i++) begin
      chk($sformatf("mid_rst_rdy%0d", i), ir[i], 1'b0);
      chk($sformatf("mid_rst_valid%0d", i), ov[i], 1'b0);
      chk($sformatf("mid_rst_state%0d", i), os[i], '0);
      chk($sformatf("mid_rst_kidx%0d", i), ok[i], '0);
      chk($sformatf("mid_rst_err%0d", i), oe[i], 1'b0);
    end
    rst = 1'b0; #1;
    for (int i = 0; i < NCFG; i++) chk($sformatf("mid_post_rdy%0d", i), ir[i], 1'b1);
    for (int i = 0; i < 16; i++) mk[i] = '0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov != '0) seen = 1'b1;
    end
    chk("dropped_valid", seen, 1'b0);
    st = rnd128();
    run_block(4'd0, st, 1'b0, 4'd0, '0, 1'b0);
    chk("zero_key", got_s[0], st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
